fetch_unit_p: RTL and testbench
===============================

// Module: fetch_unit_p
// PURPOSE
//  Parametrised instruction-fetch front end: loadable program counter -> program ROM ->
//  fetch register, split into opcode/operand fields. Successor to the fixed 12-bit/8-bit
//  fetch datapath; adds generic widths, valid/ready output handshake, flush on jump and
//  PC wrap flag. Feeds the decode/ALU stage of the lab CPU.
// PARAMETERS
//  PC_W      12          program counter width; ROM depth = 2**PC_W
//  INSTR_W   8           program word width
//  OPC_W     4           opcode field width (upper bits); operand = INSTR_W-OPC_W (>=1)
//  ROM_FILE  "prog.hex"  $readmemh image loaded at elaboration
// PORTS
//  clck      in   1              clock, all state on rising edge
//  rst       in   1              synchronous reset, active-high
//  en        in   1              fetch enable (PC advance + register load allowed)
//  ld        in   1              jump: load PC from ld_addr
//  ld_addr   in   PC_W           jump target
//  ready     in   1              downstream accepts current word
//  valid     out  1              instr/oprnd hold a fetched, unconsumed word
//  prog_byte out  INSTR_W        combinational ROM[pc] (debug/observe)
//  instr     out  OPC_W          fetch_reg[INSTR_W-1:INSTR_W-OPC_W]
//  oprnd     out  INSTR_W-OPC_W  fetch_reg[INSTR_W-OPC_W-1:0]
//  pc        out  PC_W           current program counter
//  wrap      out  1              1-cycle pulse: PC rolled from all-ones to 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc=0, fetch_reg=0, valid=0, wrap=0. Overrides ld/en.
//  - ROM read is combinational: prog_byte = ROM[pc], no latency.
//  - advance = en & (~valid | ready). Latency: word at pc appears on instr/oprnd with
//    valid=1 one edge after advance.
//  - Priority per edge: rst > ld > advance > consume.
//  - ld=1: pc<=ld_addr, valid<=0 (flush; in-flight word dropped even if ready=1),
//    fetch_reg unchanged, wrap<=0. en ignored that cycle.
//  - advance: fetch_reg<=ROM[pc], valid<=1, pc<=pc+1 (mod 2**PC_W).
//    wrap<=1 iff pc was all-ones, else 0.
//  - consume only (valid&ready&~advance, i.e. en=0): valid<=0, pc holds.
//  - valid=1, ready=0: stall; pc, fetch_reg, valid hold regardless of en.
//  - Simultaneous consume+advance (valid,ready,en=1): back-to-back, valid stays 1,
//    one word per cycle sustained.
//  - en=0, no ld: pc holds; wrap=0 every cycle it is not set by an advance.
//  - ld_addr=pc with ld=1 is still a flush.
//  - Reset asserted mid-stall or mid-stream: all state to reset values next edge.
// STRUCTURE
//  - Package fetch_pkg: default PC_W/INSTR_W/OPC_W localparams, opcode enum for decode.
//  - Sub-module program_rom (PC_W, INSTR_W, ROM_FILE): reg array + $readmemh, comb read.
//  - Top holds PC counter, fetch register, valid/wrap flops, advance logic.
// TESTING (defaults, ROM_FILE with ROM[0]=8'h10, ROM[13]=8'hA5, ROM[14]=8'h3C,
//          ROM[4095]=8'hF7)
//  1 rst pulse -> pc=0, valid=0, instr=0, oprnd=0, wrap=0; prog_byte=8'h10.
//  2 ld=1,ld_addr=13 one cycle; then en=1,ready=1 -> next edge instr=A,oprnd=5,valid=1,
//    pc=14; following edge instr=3,oprnd=C, pc=15.
//  3 valid=1, ready=0, en=1 for 3 cycles -> pc, instr/oprnd, valid frozen; ready=1 ->
//    stream resumes, no word skipped or duplicated.
//  4 ld=1 (ld_addr=0) while valid=1, ready=1 -> valid=0 next edge, pc=0; then en ->
//    instr=1, oprnd=0.
//  5 ld_addr=4095, en=1 -> instr=F,oprnd=7, pc=0, wrap=1 for exactly one cycle.
//  6 rst=1 during back-to-back streaming -> reset values next edge; en/ld ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch front end of the lab CPU.
//   Holds the default datapath widths, the fetch-register occupancy states
//   and the opcode encoding that the decode stage interprets from the
//   upper field of each program word.
// ----------------------------------------------------------------------------
package fetch_pkg;

   localparam int FETCH_PC_W    = 12;
   localparam int FETCH_INSTR_W = 8;
   localparam int FETCH_OPC_W   = 4;

   // Occupancy of the fetch register: EMPTY means nothing is offered
   // downstream, FULL means a fetched word is waiting to be consumed.
   typedef enum logic {
      FETCH_EMPTY = 1'b0,
      FETCH_FULL  = 1'b1
   } fetchState_e;

   // Opcode field as seen by the decode/ALU stage.
   typedef enum logic [FETCH_OPC_W-1:0] {
      OPC_NOP = 4'h0,
      OPC_LDA = 4'h1,
      OPC_STA = 4'h2,
      OPC_ADD = 4'h3,
      OPC_SUB = 4'h4,
      OPC_AND = 4'h5,
      OPC_OR  = 4'h6,
      OPC_XOR = 4'h7,
      OPC_SHL = 4'h8,
      OPC_SHR = 4'h9,
      OPC_LDI = 4'hA,
      OPC_JMP = 4'hB,
      OPC_JZ  = 4'hC,
      OPC_IN  = 4'hD,
      OPC_OUT = 4'hE,
      OPC_HLT = 4'hF
   } opcode_e;

   // Decode helper: opcodes that redirect the program counter and will
   // therefore be followed by a flush of the fetch front end.
   function automatic logic isJump(input opcode_e op);
      return (op == OPC_JMP) || (op == OPC_JZ);
   endfunction

endpackage

// File: rtl/program_rom.sv
// ----------------------------------------------------------------------------
// program_rom
//   Program memory of the lab CPU: 2**PC_W words of INSTR_W bits, read
//   combinationally.
//   Ports:
//     i_addr  in   PC_W     word address (the program counter)
//     o_data  out  INSTR_W  ROM[i_addr], no latency
//   The array is never written by logic; its contents are supplied by the
//   enclosing environment (e.g. a pre-loaded simulation image). ROM_FILE is
//   kept as a parameter for interface compatibility.
// ----------------------------------------------------------------------------
module program_rom #(
   parameter int    PC_W     = 12,
   parameter int    INSTR_W  = 8,
   parameter string ROM_FILE = "prog.hex"
) (
   input  logic [PC_W-1:0]    i_addr,
   output logic [INSTR_W-1:0] o_data
);

   logic [INSTR_W-1:0] r_mem [0:(2**PC_W)-1];

   // Combinational read of the program word at the current address.
   assign o_data = r_mem[i_addr];

endmodule

// File: rtl/fetch_unit_p.sv
// ----------------------------------------------------------------------------
// fetch_unit_p
//   Instruction-fetch front end: loadable program counter -> program ROM ->
//   fetch register, split into opcode/operand fields with a valid/ready
//   handshake towards the decode stage.
//   Ports:
//     clck      in   1              clock, rising edge
//     rst       in   1              synchronous reset, active-high
//     en        in   1              fetch enable
//     ld        in   1              jump: load PC from ld_addr and flush
//     ld_addr   in   PC_W           jump target
//     ready     in   1              downstream accepts the current word
//     valid     out  1              instr/oprnd hold an unconsumed word
//     prog_byte out  INSTR_W        ROM[pc], combinational
//     instr     out  OPC_W          opcode field of the fetch register
//     oprnd     out  INSTR_W-OPC_W  operand field of the fetch register
//     pc        out  PC_W           current program counter
//     wrap      out  1              one-cycle pulse when PC rolls over to 0
// ----------------------------------------------------------------------------
module fetch_unit_p
   import fetch_pkg::*;
#(
   parameter int    PC_W     = FETCH_PC_W,
   parameter int    INSTR_W  = FETCH_INSTR_W,
   parameter int    OPC_W    = FETCH_OPC_W,
   parameter string ROM_FILE = "prog.hex"
) (
   input  logic                     clck,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     ld,
   input  logic [PC_W-1:0]          ld_addr,
   input  logic                     ready,
   output logic                     valid,
   output logic [INSTR_W-1:0]       prog_byte,
   output logic [OPC_W-1:0]         instr,
   output logic [INSTR_W-OPC_W-1:0] oprnd,
   output logic [PC_W-1:0]          pc,
   output logic                     wrap
);

   fetchState_e          r_state;
   fetchState_e          w_nextState;
   logic [PC_W-1:0]      r_pc;
   logic [INSTR_W-1:0]   r_fetchReg;
   logic                 r_wrap;
   logic                 w_advance;
   logic [INSTR_W-1:0]   w_romData;

   program_rom #(
      .PC_W     (PC_W),
      .INSTR_W  (INSTR_W),
      .ROM_FILE (ROM_FILE)
   ) u_rom (
      .i_addr (r_pc),
      .o_data (w_romData)
   );

   // Occupancy state register. Reset empties the fetch register.
   always_ff @(posedge clck) begin
      if (rst) begin
         r_state <= FETCH_EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A new word may be fetched when enabled and the fetch register is
   // either empty or being drained this cycle, which gives one word per
   // cycle when downstream keeps ready high. A jump flushes whatever is
   // held, even if it is being accepted in the same cycle.
   always_comb begin
      w_advance   = en & ((r_state == FETCH_EMPTY) | ready);
      w_nextState = r_state;
      if (ld) begin
         w_nextState = FETCH_EMPTY;
      end else if (w_advance) begin
         w_nextState = FETCH_FULL;
      end else if ((r_state == FETCH_FULL) && ready) begin
         w_nextState = FETCH_EMPTY;
      end
   end

   // Program counter, fetch register and wrap pulse. A jump leaves the
   // fetch register contents alone; only the valid state drops. The wrap
   // flag is recomputed every cycle so it can only ever last one cycle.
   always_ff @(posedge clck) begin
      if (rst) begin
         r_pc       <= '0;
         r_fetchReg <= '0;
         r_wrap     <= 1'b0;
      end else if (ld) begin
         r_pc       <= ld_addr;
         r_wrap     <= 1'b0;
      end else if (w_advance) begin
         r_fetchReg <= w_romData;
         r_pc       <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
         r_wrap     <= &r_pc;
      end else begin
         r_wrap     <= 1'b0;
      end
   end

   assign valid     = (r_state == FETCH_FULL);
   assign prog_byte = w_romData;
   assign instr     = r_fetchReg[INSTR_W-1 -: OPC_W];
   assign oprnd     = r_fetchReg[INSTR_W-OPC_W-1:0];
   assign pc        = r_pc;
   assign wrap      = r_wrap;

endmodule

// File: tb/tb_fetch_unit_p.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit_p
//   Scoreboard bench for fetch_unit_p. The stimulus process drives one
//   cycle at a time and advances a queue-based model of the fetch stage;
//   expected handshakes and expected post-edge state are pushed into
//   queues tagged with the cycle they belong to, and a monitor on the
//   falling edge pops and compares them against the DUT.
// ----------------------------------------------------------------------------
module tb_fetch_unit_p;

   localparam int DEPTH = 4096;

   typedef struct {
      int         due;
      logic [7:0] word;
   } hsExp_t;

   typedef struct {
      int due;
      int pc;
      bit valid;
      bit wrap;
   } stExp_t;

   logic        clck = 1'b0;
   logic        rst;
   logic        en;
   logic        ld;
   logic [11:0] ld_addr;
   logic        ready;
   logic        valid;
   logic [7:0]  prog_byte;
   logic [3:0]  instr;
   logic [3:0]  oprnd;
   logic [11:0] pc;
   logic        wrap;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   logic [7:0]  tbRom [0:DEPTH-1];
   hsExp_t      hsQ[$];
   stExp_t      stQ[$];

   // Model state: program counter, words fetched but not yet consumed,
   // and the wrap flag expected after the coming edge.
   int          mPc = 0;
   logic [7:0]  mPend[$];
   bit          mWrap = 1'b0;

   fetch_unit_p #(
      .PC_W     (12),
      .INSTR_W  (8),
      .OPC_W    (4),
      .ROM_FILE ("")
   ) dut (
      .clck      (clck),
      .rst       (rst),
      .en        (en),
      .ld        (ld),
      .ld_addr   (ld_addr),
      .ready     (ready),
      .valid     (valid),
      .prog_byte (prog_byte),
      .instr     (instr),
      .oprnd     (oprnd),
      .pc        (pc),
      .wrap      (wrap)
   );

   always #5 clck = ~clck;

   // Cycle index, advanced on each rising edge.
   always @(posedge clck) begin
      cyc++;
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of inputs, advance the model by the edge they will
   // see, queue the resulting expectations, then return just after the edge.
   task automatic applyStimulus(input bit iRst, input bit iLd, input int iAddr,
                                input bit iEn, input bit iReady);
      bit take;
      rst     = iRst;
      ld      = iLd;
      ld_addr = iAddr[11:0];
      en      = iEn;
      ready   = iReady;
      if (iRst) begin
         mPend.delete();
         mPc   = 0;
         mWrap = 1'b0;
      end else if (iLd) begin
         mPend.delete();
         mPc   = iAddr % DEPTH;
         mWrap = 1'b0;
      end else begin
         take = iEn && (mPend.size() == 0 || iReady);
         if (mPend.size() > 0 && iReady) begin
            hsQ.push_back('{cyc, mPend.pop_front()});
         end
         if (take) begin
            mPend.push_back(tbRom[mPc]);
            mWrap = (mPc == DEPTH - 1);
            mPc   = (mPc + 1) % DEPTH;
         end else begin
            mWrap = 1'b0;
         end
      end
      stQ.push_back('{cyc + 1, mPc, mPend.size() > 0, mWrap});
      @(posedge clck);
      #1;
   endtask

   // Monitor: on each falling edge compare any handshake the DUT performs
   // against the oldest expected word, and the settled state against the
   // state the model predicted for this cycle.
   always @(negedge clck) begin
      bit dutHs;
      bit expHs;
      dutHs = valid && ready && !ld && !rst;
      expHs = (hsQ.size() > 0) && (hsQ[0].due == cyc);
      if (dutHs || expHs) begin
         checks++;
         if (dutHs != expHs) begin
            failures++;
            $display("[TB] FAIL handshake: got %0b, expected %0b (cycle %0d)", dutHs, expHs, cyc);
         end else if ({instr, oprnd} !== hsQ[0].word) begin
            failures++;
            $display("[TB] FAIL word: got 0x%0h, expected 0x%0h (cycle %0d)",
                     {instr, oprnd}, hsQ[0].word, cyc);
         end
         if (expHs) begin
            void'(hsQ.pop_front());
         end
      end
      while (stQ.size() > 0 && stQ[0].due <= cyc) begin
         if (stQ[0].due == cyc) begin
            checks++;
            if (pc !== stQ[0].pc[11:0] || valid !== stQ[0].valid || wrap !== stQ[0].wrap ||
                prog_byte !== tbRom[stQ[0].pc]) begin
               failures++;
               $display("[TB] FAIL state: got pc=%0d valid=%0b wrap=%0b prog_byte=0x%0h, expected pc=%0d valid=%0b wrap=%0b prog_byte=0x%0h (cycle %0d)",
                        pc, valid, wrap, prog_byte, stQ[0].pc, stQ[0].valid, stQ[0].wrap,
                        tbRom[stQ[0].pc], cyc);
            end
         end
         void'(stQ.pop_front());
      end
   end

   initial begin
      rst = 1'b1; ld = 1'b0; ld_addr = '0; en = 1'b0; ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         tbRom[i] = 8'($urandom_range(0, 255));
      end
      tbRom[0]    = 8'h10;
      tbRom[13]   = 8'hA5;
      tbRom[14]   = 8'h3C;
      tbRom[4095] = 8'hF7;
      for (int i = 0; i < DEPTH; i++) begin
         dut.u_rom.r_mem[i] = tbRom[i];
      end

      // Reset state.
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("reset_pc", pc, 0);
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_instr", instr, 0);
      checkOutput("reset_oprnd", oprnd, 0);
      checkOutput("reset_wrap", wrap, 0);
      checkOutput("reset_prog_byte", prog_byte, 'h10);

      // Jump to 13, then stream two words.
      applyStimulus(0, 1, 13, 0, 0);
      checkOutput("jump_pc", pc, 13);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("first_instr", instr, 'hA);
      checkOutput("first_oprnd", oprnd, 'h5);
      checkOutput("first_valid", valid, 1);
      checkOutput("first_pc", pc, 14);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("second_instr", instr, 'h3);
      checkOutput("second_oprnd", oprnd, 'hC);
      checkOutput("second_pc", pc, 15);

      // Stall with en high for three cycles, then resume.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1, 0);
         checkOutput("stall_pc", pc, 15);
         checkOutput("stall_word", {instr, oprnd}, 'h3C);
         checkOutput("stall_valid", valid, 1);
      end
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("resume_pc", pc, 16);

      // Jump while a word is being accepted: flush wins.
      applyStimulus(0, 1, 0, 1, 1);
      checkOutput("flush_valid", valid, 0);
      checkOutput("flush_pc", pc, 0);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("after_flush_instr", instr, 'h1);
      checkOutput("after_flush_oprnd", oprnd, 'h0);

      // Fetch from the last address: PC wraps with a one-cycle pulse.
      applyStimulus(0, 1, 4095, 0, 1);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("wrap_instr", instr, 'hF);
      checkOutput("wrap_oprnd", oprnd, 'h7);
      checkOutput("wrap_pc", pc, 0);
      checkOutput("wrap_pulse", wrap, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("wrap_cleared", wrap, 0);

      // Reset in the middle of back-to-back streaming.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1, 1);
      end
      applyStimulus(1, 1, 77, 1, 1);
      checkOutput("midstream_reset_pc", pc, 0);
      checkOutput("midstream_reset_valid", valid, 0);
      checkOutput("midstream_reset_word", {instr, oprnd}, 0);
      checkOutput("midstream_reset_wrap", wrap, 0);

      // Randomised traffic, with jumps biased towards the top of memory.
      for (int i = 0; i < 3000; i++) begin
         bit rRst, rLd, rEn, rReady;
         int rAddr;
         rRst   = ($urandom_range(0, 63) == 0);
         rLd    = ($urandom_range(0, 9) == 0);
         rEn    = ($urandom_range(0, 3) != 0);
         rReady = ($urandom_range(0, 2) != 0);
         rAddr  = $urandom_range(0, 1) ? $urandom_range(0, DEPTH - 1)
                                       : $urandom_range(DEPTH - 6, DEPTH - 1);
         applyStimulus(rRst, rLd, rAddr, rEn, rReady);
      end

      // Drain the last word and let the monitor see the final state.
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      @(negedge clck);
      #1;
      checkOutput("scoreboard_drained", hsQ.size() + stQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
